// File: rtl/fir_filter_mac.sv
// fir_filter_mac: time-multiplexed FIR filter with one multiply-accumulate unit.
//
// A sample accepted in IDLE is shifted into a TAPS-deep delay line. The MAC
// then walks k = 0..TAPS-1 over one tap per cycle, accumulating c[k]*x[k] at
// full precision. The result is converted to OUT_W (extend, wrap or
// saturate) and presented for one DONE cycle with out_valid high.
//
// Handshake: a sample transfers on a rising edge where in_valid && in_ready.
// in_valid may be raised at any time and the source keeps input_data stable
// until the transfer. in_ready is combinational from state and rst; all other
// outputs are registered.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   coef_write_enable  coefficient write strobe (honoured only in IDLE)
//   coef_number        coefficient index (indices >= TAPS are ignored)
//   coef_value         coefficient value
//   in_valid/in_ready  input sample handshake
//   input_data         input sample
//   out_valid          one-cycle strobe marking a new output_data
//   output_data        filter result, held until the next result
//   overflow           result did not fit OUT_W, qualified like output_data
//   fsm_state          current FSM state (IDLE=0, MAC=1, DONE=2) for debug
module fir_filter_mac #(
    parameter  int DATA_W   = 8,
    parameter  int COEF_W   = 8,
    parameter  int TAPS     = 16,
    parameter  int OUT_W    = 20,
    parameter  int SIGNED   = 1,
    parameter  int SATURATE = 1,
    localparam int CN_W     = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_write_enable,
    input  logic [CN_W-1:0]   coef_number,
    input  logic [COEF_W-1:0] coef_value,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] input_data,
    output logic              out_valid,
    output logic [OUT_W-1:0]  output_data,
    output logic              overflow,
    output logic [1:0]        fsm_state
);

    localparam int ACC_W = DATA_W + COEF_W + CN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   x_line [TAPS];
    logic [COEF_W-1:0]   coef   [TAPS];
    logic [CN_W-1:0]     k;
    logic [ACC_W-1:0]    acc;

    logic [ACC_W-1:0]    x_ext;
    logic [ACC_W-1:0]    c_ext;
    logic [ACC_W-1:0]    prod;
    logic [ACC_W-1:0]    acc_sum;
    logic [OUT_W-1:0]    conv;
    logic                conv_ovf;
    logic                acc_sign;

    assign in_ready  = (state == IDLE) && !rst;
    assign fsm_state = state;

    // Operands are extended to the accumulator width before multiplying. The
    // low ACC_W bits of a two's-complement product are identical for signed
    // and unsigned interpretation, so a plain multiply serves both modes.
    always_comb begin
        x_ext   = {{(ACC_W-DATA_W){(SIGNED != 0) && x_line[k][DATA_W-1]}}, x_line[k]};
        c_ext   = {{(ACC_W-COEF_W){(SIGNED != 0) && coef[k][COEF_W-1]}}, coef[k]};
        prod    = x_ext * c_ext;
        acc_sum = acc + prod;
    end

    assign acc_sign = (SIGNED != 0) && acc_sum[ACC_W-1];

    // Conversion of the final sum (acc_sum on the last MAC cycle) to OUT_W.
    generate
        if (ACC_W < OUT_W) begin : g_extend
            assign conv     = {{(OUT_W-ACC_W){acc_sign}}, acc_sum};
            assign conv_ovf = 1'b0;
        end else if (ACC_W == OUT_W) begin : g_same
            assign conv     = acc_sum;
            assign conv_ovf = 1'b0;
        end else begin : g_narrow
            logic             fits;
            logic [OUT_W-1:0] sat_val;
            if (SIGNED != 0) begin : g_signed
                // Fits when every bit from the OUT_W sign position upward agrees.
                assign fits    = (&acc_sum[ACC_W-1:OUT_W-1]) || !(|acc_sum[ACC_W-1:OUT_W-1]);
                assign sat_val = acc_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                  : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin : g_unsigned
                // An unsigned sum can only overflow upward.
                assign fits    = !(|acc_sum[ACC_W-1:OUT_W]);
                assign sat_val = {OUT_W{1'b1}};
            end
            assign conv     = (!fits && (SATURATE != 0)) ? sat_val : acc_sum[OUT_W-1:0];
            assign conv_ovf = !fits;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            acc         <= '0;
            output_data <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_line[i] <= '0;
                coef[i]   <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A write and an accept in the same cycle both commit here;
                    // the MAC reads the coefficient bank only from the next cycle.
                    if (coef_write_enable && (int'(coef_number) < TAPS)) begin
                        coef[coef_number] <= coef_value;
                    end
                    if (in_valid) begin
                        x_line[0] <= input_data;
                        for (int i = 1; i < TAPS; i++) begin
                            x_line[i] <= x_line[i-1];
                        end
                        acc   <= '0;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (k == CN_W'(TAPS-1)) begin
                        output_data <= conv;
                        overflow    <= conv_ovf;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_filter_mac.md
# fir_filter_mac

Parametrised, time-multiplexed FIR filter: a TAPS-deep sample delay line, a writable coefficient bank and a single multiply-accumulate unit that needs TAPS cycles per output sample. It generalises the fixed 8-bit filter with width, depth, signedness and overflow-mode parameters. It adds a valid/ready input handshake, an output valid strobe and an overflow flag. It sits between a sample source and a downstream consumer; a host loads coefficients through the same write port style as the existing filter.

## Interface

- DATA_W, 8, input sample width
- COEF_W, 8, coefficient width
- TAPS, 16, number of taps (≥2); CN_W = $clog2(TAPS)
- OUT_W, 20, output width
- SIGNED, 1, 1 = two's-complement samples/coefs/output, 0 = unsigned
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low OUT_W bits)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- coef_write_enable  input  1  coefficient write strobe
- coef_number  input  CN_W  coefficient index
- coef_value  input  COEF_W  coefficient value
- in_valid  input  1  input_data valid
- in_ready  output  1  block can accept a sample
- input_data  input  DATA_W  input sample
- out_valid  output  1  one-cycle strobe, output_data new
- output_data  output  OUT_W  filter result, held until next result
- overflow  output  1  result did not fit OUT_W; valid with output_data

## Operation

- Reset (rst high at an edge): state IDLE, all coefficients 0, delay line 0, accumulator 0, output_data 0, out_valid 0, overflow 0. in_ready is 0 while rst is high.
- FSM states:
  - IDLE (in_ready=1): on in_valid&&in_ready, shift the delay line (x[k]←x[k-1]), set x[0]←input_data, clear the accumulator, set k=0, go to MAC.
  - MAC (in_ready=0): each cycle acc += c[k]*x[k], k++; after TAPS cycles go to DONE.
  - DONE (in_ready=0, out_valid=1): go to IDLE.
- Result: y = Σ c[k]*x[k] for k=0..TAPS-1; x[0] is the newest sample.
- Accumulator width ACC_W = DATA_W+COEF_W+CN_W, full precision. Products and sum are signed when SIGNED=1, unsigned otherwise.
- Output conversion:
  - ACC_W ≤ OUT_W: sign-extend (SIGNED=1) or zero-extend (SIGNED=0); overflow=0.
  - ACC_W > OUT_W and the value exceeds the OUT_W range: overflow=1. With SATURATE=1, output_data is the max or min of OUT_W (signed or unsigned range). With SATURATE=0, output_data is the low OUT_W bits.
- Coefficient writes:
  - Committed only in IDLE when coef_write_enable=1 and coef_number<TAPS.
  - Ignored in MAC, DONE or during rst. An out-of-range index is ignored.
- Write and sample accept in the same IDLE cycle: both commit at that edge, and the computation for that sample uses the new coefficient.
- Reset mid-MAC/DONE: abort with no out_valid; all state returns to reset values.
- Delay line and coefficients persist across outputs. Only rst clears them.

## Timing

- A sample accepted at edge 0:
  - MAC occupies cycles 1..TAPS.
  - DONE is cycle TAPS+1. output_data and overflow are registered at the edge entering DONE, and out_valid is high for exactly that cycle.
  - in_ready returns to 1 in cycle TAPS+2.
- Throughput: one sample per TAPS+2 cycles (18 at the default).
- All outputs are registered, except in_ready, which is decoded from state and rst.
- in_valid held high continuously: a new sample is accepted in every IDLE cycle, giving back-to-back 18-cycle periods.

## Test plan

- Impulse: set c[k]=k+1 for k=0..15, then feed 1 followed by zeros. Required: output_data 1,2,…,16, then 0, each with one out_valid pulse; overflow=0.
- Handshake/latency: hold in_valid=1 and accept at edge 0. Required: in_ready low in cycles 1..17, out_valid only in cycle 17, in_ready high in cycle 18, next accept at edge 18.
- Overflow (SIGNED=1, OUT_W=12): set all c=-128 and feed x=-128 sixteen times, giving a true sum of 262144.
  - SATURATE=1: output_data=2047, overflow=1.
  - SATURATE=0: output_data=0, overflow=1.
- Unsigned (SIGNED=0, default widths): all c=255, sixteen inputs of 255. Required: output_data=1040400, overflow=0.
- Write gating (TAPS=12):
  - A write to coef_number=13 is ignored.
  - A write during MAC is ignored; a repeat impulse proves the coefficients are unchanged.
  - A write in the same IDLE cycle as an accept is used for that sample.
- Reset mid-MAC: assert rst in MAC cycle 5. Required: no out_valid, output_data=0, overflow=0. A subsequent impulse gives a clean response with all-zero coefficients, so outputs are 0.
